// File: rtl/cnv_win_ctrl.sv
// ============================================================================
// cnv_win_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Streams a WIDTH x HEIGHT frame of 8-bit pixels in raster order and
//   produces one zero-padded 3x3 neighbourhood window per pixel, also in
//   raster order, to drive a downstream MAC array (vld_i / din).
//
//   Pixels are held in a short line buffer that covers two rows plus a few
//   pixels. No frame buffer is used. Window (r,c) needs pixel (r+1,c+1), so
//   output runs WIDTH+1 pixels behind input. After the last pixel is
//   accepted, a FLUSH phase shifts in virtual zero pixels so that the
//   remaining WIDTH+1 windows are emitted on consecutive cycles.
//
// Parameters:
//   WIDTH  - frame width in pixels  (>= 2)
//   HEIGHT - frame height in pixels (>= 2)
//
// Ports:
//   clk        in   single clock, rising edge
//   rstn       in   asynchronous active-low reset
//   start_i    in   one-cycle frame start request (honoured only in IDLE)
//   pix_vld_i  in   input pixel valid
//   pix_i      in   [7:0] input pixel, raster order
//   pix_rdy_o  out  pixel ready; a pixel is accepted on pix_vld_i & pix_rdy_o
//   win_vld_o  out  window valid (one cycle per window)
//   din_o      out  [127:0] 3x3 window. Byte 3*(m+1)+(n+1) holds pixel
//                   (r+m, c+n), or 0 outside the frame. Bits [127:72] are 0.
//   row_o      out  [$clog2(HEIGHT)-1:0] window centre row
//   col_o      out  [$clog2(WIDTH)-1:0]  window centre column
//   busy_o     out  high while in RUN or FLUSH
//   perf_cnt_o out  [31:0] count of RUN cycles without pix_vld_i.
//                   Present only when CNV_WIN_CTRL_PERF_EN is defined.
//   done_o     out  one-cycle pulse once the last window of a frame is out
//
// Optional feature:
//   Define CNV_WIN_CTRL_PERF_EN to add the perf_cnt_o stall counter.
// ============================================================================
module cnv_win_ctrl #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_i,
  input  logic                      pix_vld_i,
  input  logic [7:0]                pix_i,
  output logic                      pix_rdy_o,
  output logic                      win_vld_o,
  output logic [127:0]              din_o,
  output logic [$clog2(HEIGHT)-1:0] row_o,
  output logic [$clog2(WIDTH)-1:0]  col_o,
  output logic                      busy_o,
`ifdef CNV_WIN_CTRL_PERF_EN
  output logic [31:0]               perf_cnt_o,
`endif
  output logic                      done_o
);

  localparam int RW   = $clog2(HEIGHT);
  localparam int CW   = $clog2(WIDTH);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int KW   = $clog2(NPIX);
  // Stored pixels; the incoming pixel acts as the newest tap, which gives
  // 2*WIDTH+3 taps in total.
  localparam int TAPS = 2 * WIDTH + 2;

  localparam logic [KW-1:0] K_FIRST = KW'(WIDTH + 1);
  localparam logic [KW-1:0] K_LAST  = KW'(NPIX - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   in_cnt;
  logic [RW-1:0]   win_r;
  logic [CW-1:0]   win_c;

  logic [7:0]      line_buf [TAPS];
  logic [7:0]      tap      [TAPS+1];
  logic [71:0]     win_next;

  logic            accept;
  logic            advance;
  logic            emit;
  logic            last_win;
  logic [7:0]      shift_in;
  logic            top_edge;
  logic            bot_edge;
  logic            lft_edge;
  logic            rgt_edge;

  // pix_rdy_o is high only in RUN, so accept also means "in RUN".
  assign accept   = pix_vld_i & pix_rdy_o;
  // In FLUSH, a zero is shifted in every cycle in place of a real pixel.
  assign advance  = accept | (state == ST_FLUSH);
  assign shift_in = accept ? pix_i : 8'h00;
  // The first WIDTH+1 accepts only fill the buffer; after that, every
  // accept completes the neighbourhood of the next window.
  assign emit     = (accept & (in_cnt >= K_FIRST)) | (state == ST_FLUSH);
  assign last_win = (win_r == R_LAST) && (win_c == C_LAST);

  assign top_edge = (win_r == '0);
  assign bot_edge = (win_r == R_LAST);
  assign lft_edge = (win_c == '0);
  assign rgt_edge = (win_c == C_LAST);

  // Tap j holds the pixel j raster positions older than the one being
  // shifted in this cycle.
  assign tap[0] = shift_in;
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    assign tap[i+1] = line_buf[i];
  end

  // The window centre lags the newest pixel by WIDTH+1 positions. Its
  // neighbour (m,n) therefore sits at tap WIDTH+1 - m*WIDTH - n. Here that
  // is written with gm=m+1 and gn=n+1. Taps that fall outside the frame
  // read stale or wrapped data, so they are masked to zero.
  for (genvar gm = 0; gm < 3; gm++) begin : g_row
    for (genvar gn = 0; gn < 3; gn++) begin : g_col
      localparam int J = (2 - gm) * WIDTH + (2 - gn);
      logic keep;
      assign keep = !((gm == 0 && top_edge) || (gm == 2 && bot_edge) ||
                      (gn == 0 && lft_edge) || (gn == 2 && rgt_edge));
      assign win_next[8*(gm*3+gn) +: 8] = keep ? tap[J] : 8'h00;
    end
  end

  // The line buffer holds datapath storage only. Every tap it supplies is
  // either refilled before use or masked by the edge logic, so it has no
  // reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      line_buf[0] <= shift_in;
      for (int i = 1; i < TAPS; i++) begin
        line_buf[i] <= line_buf[i-1];
      end
    end
  end

  // Frame sequencer with registered outputs. pix_rdy_o and busy_o follow
  // the state being entered. done_o is raised from DONE, so it pulses one
  // cycle after the final window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      in_cnt    <= '0;
      win_r     <= '0;
      win_c     <= '0;
      pix_rdy_o <= 1'b0;
      win_vld_o <= 1'b0;
      din_o     <= '0;
      row_o     <= '0;
      col_o     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      win_vld_o <= 1'b0;
      done_o    <= 1'b0;

      if (emit) begin
        win_vld_o <= 1'b1;
        din_o     <= {56'h0, win_next};
        row_o     <= win_r;
        col_o     <= win_c;
        if (win_c == C_LAST) begin
          win_c <= '0;
          win_r <= win_r + RW'(1);
        end else begin
          win_c <= win_c + CW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state     <= ST_RUN;
            in_cnt    <= '0;
            win_r     <= '0;
            win_c     <= '0;
            pix_rdy_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (in_cnt == K_LAST) begin
              state     <= ST_FLUSH;
              pix_rdy_o <= 1'b0;
            end else begin
              in_cnt <= in_cnt + KW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (last_win) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
          end
        end
        ST_DONE: begin
          done_o <= 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CNV_WIN_CTRL_PERF_EN
  // Counts RUN cycles in which the source had no pixel to offer. The count
  // saturates rather than wrapping, so a long stall never reads as small.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cnt_o <= '0;
    end else if (state == ST_IDLE && start_i) begin
      perf_cnt_o <= '0;
    end else if (state == ST_RUN && !pix_vld_i && perf_cnt_o != '1) begin
      perf_cnt_o <= perf_cnt_o + 32'd1;
    end
  end
`endif

endmodule
